// File: rtl/count_capture.sv
// Event-triggered capture of a free-running count into a show-ahead FIFO.
// Optional COUNT_CAPTURE_DELTA_EN stores differences between successive captures.
module count_capture #(
  parameter int unsigned N     = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N-1:0]             count,
  input  logic                     evt,
  input  logic                     ovf_clr,
  output logic [N-1:0]             out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [N-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          evt_q;
  logic          ovf_q, ovf_d;
  logic [N-1:0]  wdata;
  logic          push, pop, accept, drop;

  assign push   = evt & ~evt_q;
  assign pop    = out_valid & out_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign accept = push & (~full | pop);
  assign drop   = push & full & ~pop;

`ifdef COUNT_CAPTURE_DELTA_EN
  logic [N-1:0] last_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      last_q <= '0;
    end else if (push) begin
      last_q <= count;
    end
  end

  assign wdata = count - last_q;
`else
  assign wdata = count;
`endif

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    ovf_d   = ovf_q;
    if (accept) wptr_d = wptr_q + AW'(1);
    if (pop)    rptr_d = rptr_q + AW'(1);
    unique case ({accept, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    if (drop) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      evt_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      evt_q   <= evt;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && accept) begin
      mem_q[wptr_q] <= wdata;
    end
  end

  assign out_data  = mem_q[rptr_q];
  assign out_valid = (level_q != '0);
  assign full      = (level_q == LW'(DEPTH));
  assign level     = level_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_count_capture.sv
// Self-checking bench for count_capture: directed cases plus random traffic
// against a queue-based reference model. Honours COUNT_CAPTURE_DELTA_EN.
module tb_count_capture;

  localparam int unsigned N     = 4;
  localparam int unsigned DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] count = '0;
  logic         evt = 1'b0;
  logic         ovf_clr = 1'b0;
  logic [N-1:0] out_data;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic         full;
  logic [2:0]   level;
  logic         overflow;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int q[$];
  bit m_prev = 1'b0;
  bit m_ovf  = 1'b0;
  int m_last = 0;

  count_capture #(.N(N), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .count    (count),
    .evt      (evt),
    .ovf_clr  (ovf_clr),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .full     (full),
    .level    (level),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("out_valid", int'(out_valid), int'(q.size() != 0));
    check("level", int'(level), q.size());
    check("full", int'(full), int'(q.size() == DEPTH));
    check("overflow", int'(overflow), int'(m_ovf));
    if (q.size() != 0) check("out_data", int'(out_data), q[0]);
  endtask

  // Apply one cycle of inputs, advance the model, then check after the edge.
  task automatic cyc(input bit r, input bit e, input bit rdy, input bit clr, input int c);
    bit push, pop, drop;
    int val;
    rst = r; evt = e; out_ready = rdy; ovf_clr = clr; count = N'(c);
    if (!r) begin
      q.delete(); m_prev = 1'b0; m_ovf = 1'b0; m_last = 0;
    end else begin
      push = e && !m_prev;
      pop  = rdy && (q.size() != 0);
      drop = push && (q.size() == DEPTH) && !pop;
`ifdef COUNT_CAPTURE_DELTA_EN
      val = (c - m_last) & ((1 << N) - 1);
`else
      val = c & ((1 << N) - 1);
`endif
      if (push) m_last = c & ((1 << N) - 1);
      if (pop) void'(q.pop_front());
      if (push && !drop) q.push_back(val);
      if (drop) m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
      m_prev = e;
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    int cnt;
    #1;
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0, 0);
    check("reset_level", int'(level), 0);
    check("reset_valid", int'(out_valid), 0);

`ifndef COUNT_CAPTURE_DELTA_EN
    // Single capture latency
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 5);
    check("single_valid", int'(out_valid), 1);
    check("single_data", int'(out_data), 5);
    check("single_level", int'(level), 1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 6);

    // Fill, overflow, then push-while-full with pop
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 0);
    for (int v = 2; v <= 10; v += 2) begin
      cyc(1'b1, 1'b1, 1'b0, 1'b0, v);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, v + 1);
    end
    check("fill_full", int'(full), 1);
    check("fill_level", int'(level), 4);
    check("fill_ovf", int'(overflow), 1);
    check("head_2", int'(out_data), 2);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 3);
    check("full_pushpop_level", int'(level), 4);
    begin
      int exp_order[4] = '{4, 6, 8, 3};
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 4);
      for (int i = 0; i < 4; i++) begin
        check("pop_order", int'(out_data), exp_order[i]);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 5);
      end
    end
    check("drained", int'(out_valid), 0);

    // Held evt yields one push across count wrap
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 0);
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, (14 + i) % 16);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 4);
    check("held_level", int'(level), 1);
    check("held_data", int'(out_data), 14);

    // Reset mid-operation with level 3 and overflow set
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 1'b1, 1'b0, 1'b0, i);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, i);
    end
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 0);
    check("pre_rst_level", int'(level), 3);
    check("pre_rst_ovf", int'(overflow), 1);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 9);
    check("rst_level", int'(level), 0);
    check("rst_valid", int'(out_valid), 0);
    check("rst_ovf", int'(overflow), 0);
    // evt already high when reset releases still captures
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 7);
    check("post_rst_push", int'(level), 1);
`else
    // Delta captures 3,7,2 -> 3,4,11
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 3);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 4);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 7);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 8);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 2);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 3);
    begin
      int exp_delta[3] = '{3, 4, 11};
      for (int i = 0; i < 3; i++) begin
        check("delta_seq", int'(out_data), exp_delta[i]);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 0);
      end
    end
`endif

    // Random traffic against the model with a free-running count
    cnt = 0;
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 49) != 0), 1'($urandom), ($urandom_range(0, 2) == 0),
          ($urandom_range(0, 15) == 0), cnt);
      cnt = (cnt + 1) % 16;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
